program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader.sv | 116 +++++++++++
 2 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the debug unit.
//   - Loader FSM state encoding
//   - Halt instruction pattern that terminates a program download
//   - Default datapath widths
package program_loader_pkg;

  localparam int unsigned DEF_NB_MEM_WIDTH   = 8;
  localparam int unsigned DEF_NB_IM_DEPTH    = 8;
  localparam int unsigned DEF_NB_INSTRUCTION = 32;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Program loader: streams bytes from a UART receiver into instruction memory.
// Loading starts on i_start and ends when a word-aligned halt instruction has
// been written or when the memory is full (the latter flags o_overflow).
//
// Ports
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_start                   one-cycle request to (re)start a download
//   i_rx_data/i_rx_valid      incoming byte, handshaked with o_rx_ready
//   o_im_enable               instruction-memory enable
//   o_im_write_enable/_data/_addr  one-cycle write strobe per accepted byte
//   o_loading/o_done          FSM status
//   o_overflow                memory filled without a halt word
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned NB_MEM_WIDTH   = DEF_NB_MEM_WIDTH,
  parameter int unsigned NB_IM_DEPTH    = DEF_NB_IM_DEPTH,
  parameter int unsigned NB_INSTRUCTION = DEF_NB_INSTRUCTION
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NB_MEM_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic                    o_im_enable,
  output logic                    o_im_write_enable,
  output logic [NB_MEM_WIDTH-1:0] o_im_write_data,
  output logic [NB_IM_DEPTH-1:0]  o_im_write_addr,
  output logic                    o_loading,
  output logic                    o_done,
  output logic                    o_overflow
);

  localparam int unsigned NbShift = NB_INSTRUCTION - NB_MEM_WIDTH;
  // Index of the byte that completes an instruction word.
  localparam logic [1:0]  LastIdx = 2'(NB_INSTRUCTION / NB_MEM_WIDTH - 1);

  loader_state_e r_state;
  loader_state_e w_state_d;

  logic [NB_IM_DEPTH-1:0]    r_addr;
  logic [1:0]                r_idx;
  logic [NbShift-1:0]        r_shift;
  logic                      r_we;
  logic [NB_MEM_WIDTH-1:0]   r_wdata;
  logic [NB_IM_DEPTH-1:0]    r_waddr;
  logic                      r_overflow;

  logic                      w_accept;
  logic                      w_start;
  logic                      w_halt;
  logic                      w_full;
  logic [NB_INSTRUCTION-1:0] w_word;

  assign w_accept = i_rx_valid && (r_state == StLoad);
  // Start is ignored while a download is in progress.
  assign w_start  = i_start && (r_state != StLoad);
  // Word being completed by the incoming byte; first byte is most significant.
  assign w_word   = {r_shift, i_rx_data};
  assign w_halt   = w_accept && (r_idx == LastIdx) &&
                    (w_word == NB_INSTRUCTION'(HALT_WORD));
  assign w_full   = w_accept && (r_addr == '1);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_d = StLoad;
      StLoad:  if (w_halt || w_full) w_state_d = StDone;
      StDone:  if (i_start) w_state_d = StLoad;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_waddr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_we    <= w_accept;
      if (w_accept) begin
        r_wdata <= i_rx_data;
        r_waddr <= r_addr;
      end
      if (w_start) begin
        r_addr     <= '0;
        r_idx      <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        // Saturate at the last address; the FSM leaves LOAD on that byte.
        if (!w_full) r_addr <= r_addr + NB_IM_DEPTH'(1);
        r_idx   <= r_idx + 2'd1;
        r_shift <= w_word[NbShift-1:0];
        if (w_full && !w_halt) r_overflow <= 1'b1;
      end
    end
  end

  assign o_rx_ready        = (r_state == StLoad);
  assign o_loading         = (r_state == StLoad);
  assign o_done            = (r_state == StDone);
  // Kept high through the final strobe, which lands after the FSM left LOAD.
  assign o_im_enable       = (r_state == StLoad) || r_we;
  assign o_im_write_enable = r_we;
  assign o_im_write_data   = r_wdata;
  assign o_im_write_addr   = r_waddr;
  assign o_overflow        = r_overflow;

endmodule
